uart_wb_master: RTL and testbench

//  Wishbone classic initiator that drives the UART register-file slave. Takes single-byte register

---
 rtl/uart_wb_master.sv | 203 ++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// Wishbone classic initiator for the UART register-file slave: one bus cycle per local command.
// Optional macro UART_WBM_TIMEOUT_EN adds an ACCESS watchdog that aborts with rsp_err_o.
module uart_wb_master #(
    parameter int DATA_BUS_WIDTH_8 = 0,
    parameter int WORD_SIZE_REGS   = 1,
    parameter int LITTLE_ENDIAN    = 1,
    parameter int ADDR_WIDTH       = 5,
    parameter int IDLE_GAP         = 2,
    parameter int TIMEOUT_CYCLES   = 16,
    localparam int DATA_WIDTH      = (DATA_BUS_WIDTH_8 != 0) ? 8 : 32
) (
    input  logic                  clk,
    input  logic                  wb_rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [7:0]            cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [7:0]            rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

`ifdef UART_WBM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]            state_q, state_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [1:0]            lane_q, lane_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_dat_q, rsp_dat_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
`ifdef UART_WBM_TIMEOUT_EN
    logic                  rsp_err_q, rsp_err_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
`endif

    logic [ADDR_WIDTH-1:0] adr_map;
    logic [1:0]            lane_sel;
    logic [31:0]           wdata_wide;
    logic [31:0]           rdata_wide;
    logic [7:0]            rd_byte;

    // Byte-lane steering: only the byte-register layout on a 32-bit bus uses lanes other than 0.
    always_comb begin
        adr_map  = cmd_adr_i;
        lane_sel = 2'b00;
        if (DATA_BUS_WIDTH_8 != 0) begin
            adr_map = cmd_adr_i;
        end else if (WORD_SIZE_REGS != 0) begin
            adr_map = {cmd_adr_i[ADDR_WIDTH-3:0], 2'b00};
        end else begin
            adr_map  = {cmd_adr_i[ADDR_WIDTH-1:2], 2'b00};
            lane_sel = (LITTLE_ENDIAN != 0) ? cmd_adr_i[1:0] : ~cmd_adr_i[1:0];
        end
    end

    assign wdata_wide = {24'h000000, cmd_dat_i} << {lane_sel, 3'b000};
    assign rdata_wide = 32'(wb_dat_i);
    assign rd_byte    = rdata_wide[{lane_q, 3'b000} +: 8];

    // Strobe rises one cycle after accept so address, select and data are already stable.
    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        lane_d      = lane_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        gap_cnt_d   = gap_cnt_q;
`ifdef UART_WBM_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d   = S_ACCESS;
                    we_d      = cmd_we_i;
                    adr_d     = adr_map;
                    sel_d     = 4'b0001 << lane_sel;
                    dat_d     = DATA_WIDTH'(wdata_wide);
                    lane_d    = lane_sel;
                    rsp_dat_d = 8'h00;
`ifdef UART_WBM_TIMEOUT_EN
                    rsp_err_d = 1'b0;
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_ACCESS: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (wb_ack_i) begin
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 8'h00 : rd_byte;
                    state_d     = S_RESP;
`ifdef UART_WBM_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                gap_cnt_d = '0;
                state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
            end
            default: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= 4'b0000;
            dat_q       <= '0;
            lane_q      <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 8'h00;
            gap_cnt_q   <= '0;
`ifdef UART_WBM_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            lane_q      <= lane_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef UART_WBM_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign wb_cyc_o    = stb_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_dat_o    = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
`ifdef UART_WBM_TIMEOUT_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: four bus configurations driven by one shared command port,
// each with a two-stage sampled-ack slave model.
module tb_uart_wb_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid, cmd_we;
    logic [4:0] cmd_adr;
    logic [7:0] cmd_dat;
    logic       ack_en, ack_force;

    // Index 0: 8-bit bus, 1: 32-bit byte regs LE, 2: 32-bit byte regs BE, 3: 32-bit word regs
    logic [3:0] cyc, stb, wb_we, ack, s1, ack_m;
    logic [3:0] cmd_ready, rsp_valid, rsp_err, busy;
    logic [4:0] adr [4];
    logic [3:0] sel [4];
    logic [7:0] rsp_dat [4];
    logic [7:0] wdat0, rdat0;
    logic [31:0] wdat1, wdat2, wdat3, rdat1, rdat2, rdat3;

    int errors = 0;
    int checks = 0;

    int          o_stb, o_cyc, o_rsp;
    logic [7:0]  o_rdat;
    logic        o_err, o_done, o_we, o_acc;
    logic [4:0]  o_adr;
    logic [3:0]  o_sel;
    logic [31:0] o_dat;

    uart_wb_master #(.DATA_BUS_WIDTH_8(1), .WORD_SIZE_REGS(1), .LITTLE_ENDIAN(1),
                     .ADDR_WIDTH(5), .IDLE_GAP(2), .TIMEOUT_CYCLES(16)) u_bus8 (
        .clk(clk), .wb_rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[0]),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid[0]), .rsp_dat_o(rsp_dat[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0]),
        .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(wb_we[0]), .wb_adr_o(adr[0]),
        .wb_sel_o(sel[0]), .wb_dat_o(wdat0), .wb_dat_i(rdat0), .wb_ack_i(ack[0]));

    uart_wb_master #(.DATA_BUS_WIDTH_8(0), .WORD_SIZE_REGS(0), .LITTLE_ENDIAN(1),
                     .ADDR_WIDTH(5), .IDLE_GAP(2), .TIMEOUT_CYCLES(16)) u_byte_le (
        .clk(clk), .wb_rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[1]),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid[1]), .rsp_dat_o(rsp_dat[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1]),
        .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(wb_we[1]), .wb_adr_o(adr[1]),
        .wb_sel_o(sel[1]), .wb_dat_o(wdat1), .wb_dat_i(rdat1), .wb_ack_i(ack[1]));

    uart_wb_master #(.DATA_BUS_WIDTH_8(0), .WORD_SIZE_REGS(0), .LITTLE_ENDIAN(0),
                     .ADDR_WIDTH(5), .IDLE_GAP(2), .TIMEOUT_CYCLES(16)) u_byte_be (
        .clk(clk), .wb_rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[2]),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid[2]), .rsp_dat_o(rsp_dat[2]), .rsp_err_o(rsp_err[2]), .busy_o(busy[2]),
        .wb_cyc_o(cyc[2]), .wb_stb_o(stb[2]), .wb_we_o(wb_we[2]), .wb_adr_o(adr[2]),
        .wb_sel_o(sel[2]), .wb_dat_o(wdat2), .wb_dat_i(rdat2), .wb_ack_i(ack[2]));

    uart_wb_master #(.DATA_BUS_WIDTH_8(0), .WORD_SIZE_REGS(1), .LITTLE_ENDIAN(1),
                     .ADDR_WIDTH(5), .IDLE_GAP(2), .TIMEOUT_CYCLES(16)) u_word (
        .clk(clk), .wb_rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[3]),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid[3]), .rsp_dat_o(rsp_dat[3]), .rsp_err_o(rsp_err[3]), .busy_o(busy[3]),
        .wb_cyc_o(cyc[3]), .wb_stb_o(stb[3]), .wb_we_o(wb_we[3]), .wb_adr_o(adr[3]),
        .wb_sel_o(sel[3]), .wb_dat_o(wdat3), .wb_dat_i(rdat3), .wb_ack_i(ack[3]));

    // Slave model: strobe sampled, then ack one cycle later, single-cycle ack.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 4'b0000;
            ack_m <= 4'b0000;
        end else begin
            s1    <= stb & ~ack_m & {4{ack_en}};
            ack_m <= s1 & stb & ~ack_m;
        end
    end
    assign ack = ack_m | {4{ack_force}};

    function automatic logic [31:0] wdat_of(input int d);
        case (d)
            0:       return {24'h000000, wdat0};
            1:       return wdat1;
            2:       return wdat2;
            default: return wdat3;
        endcase
    endfunction

    // Issues one command to all DUTs and records what DUT 'dut' does on the bus.
    task automatic do_cmd(input logic we, input logic [4:0] a, input logic [7:0] d,
                          input int dut, input int budget);
        bit seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = a; cmd_dat = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 5'd0; cmd_dat = 8'h00;
        o_acc = busy[dut];
        o_stb = 0; o_cyc = 0; o_rsp = 0; o_rdat = 8'hxx; o_err = 1'bx;
        o_we = 1'bx; o_adr = 5'hxx; o_sel = 4'hx; o_dat = 32'hxxxxxxxx;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (stb[dut]) begin
                o_stb++;
                if (!seen) begin
                    seen  = 1'b1;
                    o_we  = wb_we[dut];
                    o_adr = adr[dut];
                    o_sel = sel[dut];
                    o_dat = wdat_of(dut);
                end
            end
            if (cyc[dut]) o_cyc++;
            if (rsp_valid[dut]) begin
                o_rsp++;
                o_rdat = rsp_dat[dut];
                o_err  = rsp_err[dut];
            end
            if (!busy[dut]) break;
        end
        o_done = !busy[dut];
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (cyc !== 4'b0000 || stb !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobes: cyc=%b stb=%b required 0000", cyc, stb); end
        checks++; if (cmd_ready !== 4'b1111 || busy !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready_busy: ready=%b busy=%b required 1111/0000", cmd_ready, busy); end
        checks++; if (rsp_valid !== 4'b0000 || rsp_err !== 4'b0000 || wb_we !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp: valid=%b err=%b we=%b required 0", rsp_valid, rsp_err, wb_we); end
        checks++; if (adr[1] !== 5'd0 || sel[1] !== 4'd0 || wdat1 !== 32'd0 || rsp_dat[1] !== 8'd0) begin errors++; $display("[TB] FAIL reset_data: adr=%h sel=%h dat=%h rdat=%h required 0", adr[1], sel[1], wdat1, rsp_dat[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bus8_read();
        do_cmd(1'b0, 5'd5, 8'h00, 0, 40);
        checks++; if (o_acc !== 1'b1) begin errors++; $display("[TB] FAIL bus8_accept: busy=%b required 1", o_acc); end
        checks++; if (o_stb != 3 || o_cyc != 3) begin errors++; $display("[TB] FAIL bus8_stb_len: stb=%0d cyc=%0d required 3", o_stb, o_cyc); end
        checks++; if (o_adr !== 5'd5 || o_sel !== 4'b0001 || o_we !== 1'b0) begin errors++; $display("[TB] FAIL bus8_bus: adr=%h sel=%b we=%b required 05/0001/0", o_adr, o_sel, o_we); end
        checks++; if (o_rsp != 1 || o_rdat !== 8'hA5 || o_err !== 1'b0) begin errors++; $display("[TB] FAIL bus8_rsp: pulses=%0d dat=%h err=%b required 1/a5/0", o_rsp, o_rdat, o_err); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL bus8_done: idle=%b required 1", o_done); end
    endtask

    task automatic test_byte_lanes();
        do_cmd(1'b1, 5'd6, 8'h3C, 1, 40);
        checks++; if (o_adr !== 5'd4 || o_sel !== 4'b0100 || o_we !== 1'b1) begin errors++; $display("[TB] FAIL le_write_bus: adr=%h sel=%b we=%b required 04/0100/1", o_adr, o_sel, o_we); end
        checks++; if (o_dat !== 32'h003C0000) begin errors++; $display("[TB] FAIL le_write_dat: %h required 003c0000", o_dat); end
        checks++; if (o_rsp != 1 || o_rdat !== 8'h00) begin errors++; $display("[TB] FAIL le_write_rsp: pulses=%0d dat=%h required 1/00", o_rsp, o_rdat); end
        do_cmd(1'b1, 5'd6, 8'h3C, 2, 40);
        checks++; if (o_adr !== 5'd4 || o_sel !== 4'b0010) begin errors++; $display("[TB] FAIL be_write_bus: adr=%h sel=%b required 04/0010", o_adr, o_sel); end
        checks++; if (o_dat !== 32'h00003C00) begin errors++; $display("[TB] FAIL be_write_dat: %h required 00003c00", o_dat); end
        do_cmd(1'b0, 5'd7, 8'h00, 1, 40);
        checks++; if (o_sel !== 4'b1000 || o_rdat !== 8'h11) begin errors++; $display("[TB] FAIL le_read_lane3: sel=%b dat=%h required 1000/11", o_sel, o_rdat); end
        do_cmd(1'b0, 5'd7, 8'h00, 2, 40);
        checks++; if (o_sel !== 4'b0001 || o_rdat !== 8'h44) begin errors++; $display("[TB] FAIL be_read_lane0: sel=%b dat=%h required 0001/44", o_sel, o_rdat); end
    endtask

    task automatic test_word_regs();
        do_cmd(1'b0, 5'd3, 8'h00, 3, 40);
        checks++; if (o_adr !== 5'd12 || o_sel !== 4'b0001) begin errors++; $display("[TB] FAIL word_read_bus: adr=%0d sel=%b required 12/0001", o_adr, o_sel); end
        checks++; if (o_rsp != 1 || o_rdat !== 8'h44) begin errors++; $display("[TB] FAIL word_read_rsp: pulses=%0d dat=%h required 1/44", o_rsp, o_rdat); end
        do_cmd(1'b1, 5'd31, 8'h5A, 3, 40);
        checks++; if (o_adr !== 5'd28 || o_dat !== 32'h0000005A) begin errors++; $display("[TB] FAIL word_top_adr: adr=%0d dat=%h required 28/0000005a", o_adr, o_dat); end
    endtask

    task automatic test_back_to_back();
        int pulses, low, min_low, viol, rsps;
        bit prev, pend;
        logic [3:0]  rec_sel [2];
        logic [31:0] rec_dat [2];
        pulses = 0; low = 0; min_low = 1000; viol = 0; rsps = 0; prev = 1'b0; pend = 1'b0;
        rec_sel[0] = 4'hx; rec_sel[1] = 4'hx; rec_dat[0] = 32'hx; rec_dat[1] = 32'hx;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 5'd0; cmd_dat = 8'h11;
        @(negedge clk);
        cmd_adr = 5'd3; cmd_dat = 8'h22;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pend) begin cmd_valid = 1'b0; pend = 1'b0; end
            if (stb[1] && !prev) begin
                if (pulses < 2) begin rec_sel[pulses] = sel[1]; rec_dat[pulses] = wdat1; end
                if (pulses > 0 && low < min_low) min_low = low;
                pulses++;
            end
            if (stb[1]) low = 0; else low++;
            if (busy[1] && cmd_ready[1]) viol++;
            if (rsp_valid[1]) rsps++;
            prev = stb[1];
            if (cmd_valid && cmd_ready[1]) pend = 1'b1;
        end
        cmd_valid = 1'b0;
        checks++; if (pulses != 2 || rsps != 2) begin errors++; $display("[TB] FAIL b2b_count: stb pulses=%0d rsp=%0d required 2/2", pulses, rsps); end
        checks++; if (min_low < 2) begin errors++; $display("[TB] FAIL b2b_gap: low cycles=%0d required >=2", min_low); end
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL b2b_ready_busy: overlap cycles=%0d required 0", viol); end
        checks++; if (rec_sel[0] !== 4'b0001 || rec_dat[0] !== 32'h00000011) begin errors++; $display("[TB] FAIL b2b_first: sel=%b dat=%h required 0001/00000011", rec_sel[0], rec_dat[0]); end
        checks++; if (rec_sel[1] !== 4'b1000 || rec_dat[1] !== 32'h22000000) begin errors++; $display("[TB] FAIL b2b_second: sel=%b dat=%h required 1000/22000000", rec_sel[1], rec_dat[1]); end
    endtask

    task automatic test_no_ack();
        int late;
        ack_en = 1'b0;
`ifdef UART_WBM_TIMEOUT_EN
        do_cmd(1'b0, 5'd5, 8'h00, 0, 60);
        checks++; if (o_stb != 16) begin errors++; $display("[TB] FAIL tmo_stb_len: %0d required 16", o_stb); end
        checks++; if (o_rsp != 1 || o_err !== 1'b1 || o_rdat !== 8'h00) begin errors++; $display("[TB] FAIL tmo_rsp: pulses=%0d err=%b dat=%h required 1/1/00", o_rsp, o_err, o_rdat); end
        late = 0;
        ack_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0] || stb[0] || busy[0]) late++;
        end
        ack_force = 1'b0;
        checks++; if (late != 0) begin errors++; $display("[TB] FAIL tmo_late_ack: reacting cycles=%0d required 0", late); end
        ack_en = 1'b1;
`else
        do_cmd(1'b0, 5'd5, 8'h00, 0, 40);
        checks++; if (o_done !== 1'b0 || o_rsp != 0 || stb[0] !== 1'b1) begin errors++; $display("[TB] FAIL wait_forever: idle=%b rsp=%0d stb=%b required 0/0/1", o_done, o_rsp, stb[0]); end
        ack_en = 1'b1;
        late = 0;
        for (int n = 0; n < 20 && late == 0; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                late = 1;
                checks++; if (rsp_dat[0] !== 8'hA5 || rsp_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL wait_rsp: dat=%h err=%b required a5/0", rsp_dat[0], rsp_err[0]); end
            end
        end
        checks++; if (late != 1) begin errors++; $display("[TB] FAIL wait_rsp_seen: %0d required 1", late); end
        repeat (6) @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_access();
        int bad_rsp, not_ready;
        ack_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 5'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (stb[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_access: stb=%b required 1", stb[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cyc !== 4'b0000 || stb !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("[TB] FAIL rst_async: cyc=%b stb=%b busy=%b required 0", cyc, stb, busy); end
        checks++; if (adr[0] !== 5'd0 || rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rst_async_regs: adr=%h rsp_valid=%b required 0", adr[0], rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        bad_rsp = 0; not_ready = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid != 4'b0000) bad_rsp++;
            if (cmd_ready[0] !== 1'b1) not_ready++;
        end
        checks++; if (bad_rsp != 0 || not_ready != 0) begin errors++; $display("[TB] FAIL rst_after_release: rsp cycles=%0d not-ready cycles=%0d required 0/0", bad_rsp, not_ready); end
        do_cmd(1'b0, 5'd5, 8'h00, 0, 40);
        checks++; if (o_rsp != 1 || o_rdat !== 8'hA5) begin errors++; $display("[TB] FAIL rst_recover: pulses=%0d dat=%h required 1/a5", o_rsp, o_rdat); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 5'd0; cmd_dat = 8'h00;
        ack_en = 1'b1; ack_force = 1'b0;
        rdat0 = 8'hA5; rdat1 = 32'h11223344; rdat2 = 32'h11223344; rdat3 = 32'h11223344;
        test_reset();
        test_bus8_read();
        test_byte_lanes();
        test_word_regs();
        test_back_to_back();
        test_no_ack();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
